multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences one instruction over 3–5 states, sharing a single ALU, a single memory port and the instruction/data registers.
- Drives the ALU decoder's 2-bit aluop (00 add, 01 sub, 10 use funct); the decoder is unchanged.
- Handles a memory ready handshake, flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_control.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore output decode, memory ready handshake, illegal-op flag, retire counter.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcen,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             bad_op;

  logic             mem_req_c;
  logic             memwrite_c;
  logic             irwrite_c;
  logic             regwrite_c;
  logic             pcwrite_c;
  logic             branch_c;

  // Next state, retirement and illegal-opcode detection.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    bad_op  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (op)
          OP_LW,
          OP_SW:   state_d = S_MEMADR;
          OP_R:    state_d = S_EXEC;
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            bad_op  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDIEX: begin
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  // Moore datapath control decode; only memory strobes see mem_ready.
  always_comb begin
    mem_req_c  = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alusrcb   = 2'b01;
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        mem_req_c  = 1'b1;
        iord       = 1'b1;
        memwrite_c = mem_ready;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_c = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_c = 1'b1;
      end
      default: begin
        alusrcb = 2'b01;
      end
    endcase
  end

  // Strobes are held low for the whole time reset is asserted.
  always_comb begin
    mem_req  = reset_n & mem_req_c;
    memwrite = reset_n & memwrite_c;
    irwrite  = reset_n & irwrite_c;
    regwrite = reset_n & regwrite_c;
    pcen     = reset_n & (pcwrite_c | (branch_c & zero));
    illegal  = reset_n & bad_op;
    instret  = instret_q;
  end

  // State and retire counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control.
// Instruction-level reference model feeds expected per-cycle controls.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [5:0]  op = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, iord, memwrite, irwrite, pcen;
  logic        regwrite, regdst, memtoreg, alusrca, illegal;
  logic [1:0]  alusrcb, pcsrc, aluop;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
    .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .aluop(aluop), .illegal(illegal), .instret(instret)
  );

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t        c;
    logic [31:0] n;
  } exp_t;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  exp_t        sb[$];
  exp_t        e_m;
  ctl_t        act;
  int          checks = 0;
  int          passed = 0;
  int          cyc_no = 0;
  logic [31:0] n_m = '0;

  assign act = {mem_req, iord, memwrite, irwrite, pcen, regwrite,
                regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop,
                illegal};

  // Monitor: compare every presented cycle against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e_m = sb.pop_front();
        checks++;
        if (act === e_m.c) passed++;
        else $display("FAIL ctl cyc %0d: got %h want %h",
                      cyc_no, act, e_m.c);
        checks++;
        if (instret === e_m.n) passed++;
        else $display("FAIL instret cyc %0d: got %0d want %0d",
                      cyc_no, instret, e_m.n);
        cyc_no++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return o inside {LW, SW, RT, BEQ, ADDI, JMP};
  endfunction

  task automatic cyc(input ctl_t e, input logic [5:0] o,
                     input logic z, input logic mr);
    op        = o;
    zero      = z;
    mem_ready = mr;
    sb.push_back({e, n_m});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    ctl_t e;
    reset_n   = 1'b0;
    n_m       = '0;
    e         = '0;
    e.alusrcb = 2'b01;
    repeat (n) cyc(e, rop(), rb(), rb());
    reset_n = 1'b1;
  endtask

  task automatic fetch(input int w);
    ctl_t e;
    e         = '0;
    e.mem_req = 1'b1;
    e.alusrcb = 2'b01;
    repeat (w) cyc(e, rop(), rb(), 1'b0);
    e.irwrite = 1'b1;
    e.pcen    = 1'b1;
    cyc(e, rop(), rb(), 1'b1);
  endtask

  // zf: 0/1 forces zero in BRANCH, 2 randomises it.
  task automatic instr(input logic [5:0] o, input int zf,
                       input int wf, input int wm);
    ctl_t e;
    logic z;
    fetch(wf);
    e         = '0;
    e.alusrcb = 2'b11;
    e.illegal = !legal(o);
    cyc(e, o, rb(), rb());
    if (!legal(o)) return;
    case (o)
      LW, SW: begin
        e         = '0;
        e.alusrca = 1'b1;
        e.alusrcb = 2'b10;
        cyc(e, o, rb(), rb());
        e         = '0;
        e.mem_req = 1'b1;
        e.iord    = 1'b1;
        repeat (wm) cyc(e, rop(), rb(), 1'b0);
        if (o == LW) begin
          cyc(e, rop(), rb(), 1'b1);
          e          = '0;
          e.memtoreg = 1'b1;
          e.regwrite = 1'b1;
          cyc(e, rop(), rb(), rb());
        end else begin
          e.memwrite = 1'b1;
          cyc(e, rop(), rb(), 1'b1);
        end
      end
      RT: begin
        e         = '0;
        e.alusrca = 1'b1;
        e.aluop   = 2'b10;
        cyc(e, rop(), rb(), rb());
        e          = '0;
        e.regdst   = 1'b1;
        e.regwrite = 1'b1;
        cyc(e, rop(), rb(), rb());
      end
      BEQ: begin
        z         = (zf == 2) ? rb() : zf[0];
        e         = '0;
        e.alusrca = 1'b1;
        e.aluop   = 2'b01;
        e.pcsrc   = 2'b01;
        e.pcen    = z;
        cyc(e, rop(), z, rb());
      end
      ADDI: begin
        e         = '0;
        e.alusrca = 1'b1;
        e.alusrcb = 2'b10;
        cyc(e, rop(), rb(), rb());
        e          = '0;
        e.regwrite = 1'b1;
        cyc(e, rop(), rb(), rb());
      end
      default: begin
        e       = '0;
        e.pcsrc = 2'b10;
        e.pcen  = 1'b1;
        cyc(e, rop(), rb(), rb());
      end
    endcase
    n_m = n_m + 32'd1;
  endtask

  task automatic lw_abort();
    ctl_t e;
    fetch(0);
    e         = '0;
    e.alusrcb = 2'b11;
    cyc(e, LW, rb(), rb());
    e         = '0;
    e.alusrca = 1'b1;
    e.alusrcb = 2'b10;
    cyc(e, LW, rb(), rb());
    e         = '0;
    e.mem_req = 1'b1;
    e.iord    = 1'b1;
    cyc(e, rop(), rb(), 1'b0);
    do_reset(2);
  endtask

  // Stimulus: directed scenarios, then randomized instruction stream.
  initial begin
    int k;
    @(posedge clk);
    #1;
    do_reset(2);
    instr(LW, 2, 0, 0);
    instr(RT, 2, 0, 0);
    instr(BEQ, 1, 0, 0);
    instr(BEQ, 0, 0, 0);
    instr(SW, 2, 0, 3);
    instr(6'b111111, 2, 0, 0);
    instr(JMP, 2, 0, 0);
    instr(ADDI, 2, 1, 0);
    lw_abort();
    instr(RT, 2, 0, 0);
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: instr(LW, 2, $urandom_range(0, 2), $urandom_range(0, 3));
        1: instr(SW, 2, $urandom_range(0, 2), $urandom_range(0, 3));
        2: instr(RT, 2, $urandom_range(0, 2), 0);
        3: instr(BEQ, 2, $urandom_range(0, 2), 0);
        4: instr(ADDI, 2, $urandom_range(0, 2), 0);
        5: instr(JMP, 2, $urandom_range(0, 2), 0);
        default: instr(rop(), 2, $urandom_range(0, 2), 0);
      endcase
      if ($urandom_range(0, 39) == 0) do_reset(1);
    end
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
